// File: rtl/box_250mhz_p4_out_if.sv
// Stream and metadata signals between the P4 core, the output adapter and the downstream sink.
// The slave modport is the adapter's view; master is the view of the logic driving it.
interface box_250mhz_p4_out_if #(
  parameter int TDATA_W    = 1024,
  parameter int USERMETA_W = 1088
);
  logic                    s_axis_tvalid;
  logic [TDATA_W-1:0]      s_axis_tdata;
  logic [TDATA_W/8-1:0]    s_axis_tkeep;
  logic                    s_axis_tlast;
  logic                    s_axis_tready;
  logic [USERMETA_W-1:0]   user_metadata_out;
  logic                    user_metadata_out_valid;
  logic                    m_axis_tvalid;
  logic [TDATA_W-1:0]      m_axis_tdata;
  logic [TDATA_W/8-1:0]    m_axis_tkeep;
  logic                    m_axis_tlast;
  logic [63:0]             m_axis_tuser;
  logic                    m_axis_tready;

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast,
    input  user_metadata_out, user_metadata_out_valid, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep,
    output m_axis_tlast, m_axis_tuser
  );

  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast,
    output user_metadata_out, user_metadata_out_valid, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep,
    input  m_axis_tlast, m_axis_tuser
  );
endinterface

// File: rtl/box_250mhz_p4_out.sv
// Rejoins queued per-packet P4 metadata to its packet as tuser; data path is combinational,
// metadata visible 1 cycle after its strobe; packets are held off (tready=0) until metadata is queued.
module box_250mhz_p4_out #(
  parameter int TDATA_W    = 1024,
  parameter int USERMETA_W = 1088,
  parameter int META_DEPTH = 8
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  box_250mhz_p4_out_if.slave            axis,
  output logic [$clog2(META_DEPTH):0]   meta_count,
  output logic                          meta_overflow,
  output logic [31:0]                   pkt_count
);
  localparam int PW = $clog2(META_DEPTH);
  localparam int CW = PW + 1;

  logic [63:0]   r_mem [META_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic [31:0]   r_pkt_count;

  logic w_empty;
  logic w_full;
  logic w_out_vld;
  logic w_push;
  logic w_pop;
  logic w_drop;
  logic w_unused_meta;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(META_DEPTH));
  assign w_out_vld = axis.s_axis_tvalid & ~w_empty;
  assign w_pop     = w_out_vld & axis.m_axis_tready & axis.s_axis_tlast;
  // A pop in the same cycle frees a slot, so a strobe at full is still accepted.
  assign w_push    = axis.user_metadata_out_valid & (~w_full | w_pop);
  assign w_drop    = axis.user_metadata_out_valid & w_full & ~w_pop;

  assign w_unused_meta = ^axis.user_metadata_out[USERMETA_W-1:64];

  assign axis.m_axis_tvalid = w_out_vld;
  assign axis.s_axis_tready = axis.m_axis_tready & ~w_empty;
  assign axis.m_axis_tdata  = axis.s_axis_tdata;
  assign axis.m_axis_tkeep  = axis.s_axis_tkeep;
  assign axis.m_axis_tlast  = axis.s_axis_tlast;
  assign axis.m_axis_tuser  = r_mem[r_rd_ptr];

  assign meta_count    = r_count;
  assign meta_overflow = r_overflow;
  assign pkt_count     = r_pkt_count;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_pkt_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
      r_pkt_count <= r_pkt_count + {31'd0, w_pop};
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge aclk) begin
    if (w_push) r_mem[r_wr_ptr] <= axis.user_metadata_out[63:0];
  end
endmodule

// File: doc/box_250mhz_p4_out.md
# box_250mhz_p4_out

Output-side adapter for the P4 pipeline in the 250 MHz user box. It takes the packet stream and the per-packet `user_metadata_out` pulse from the P4 core, and queues the metadata in a small FIFO. It then rejoins each metadata word to its packet and emits a standard AXI4-Stream with the low 64 metadata bits driven on `m_axis_tuser` for every beat of that packet. It is the mirror of the input-side adapter, which strips `tuser` into `user_metadata_in`.

## Interface
- `TDATA_W`, 1024, stream data width in bits.
- `USERMETA_W`, 1088, P4 user metadata width; only bits [63:0] are forwarded.
- `META_DEPTH`, 8, metadata FIFO depth; power of two, ≥2.

- `aclk`  in  1  clock.
- `aresetn`  in  1  reset, synchronous, active-low.
- `s_axis_tvalid`  in  1  packet beat valid from P4 core.
- `s_axis_tdata`  in  TDATA_W  packet data.
- `s_axis_tkeep`  in  TDATA_W/8  byte enables.
- `s_axis_tlast`  in  1  last beat of packet.
- `s_axis_tready`  out  1  ready to P4 core.
- `user_metadata_out`  in  USERMETA_W  per-packet metadata from P4 core.
- `user_metadata_out_valid`  in  1  single-cycle metadata strobe; no backpressure.
- `m_axis_tvalid`  out  1  output beat valid.
- `m_axis_tdata`  out  TDATA_W  = `s_axis_tdata`.
- `m_axis_tkeep`  out  TDATA_W/8  = `s_axis_tkeep`.
- `m_axis_tlast`  out  1  = `s_axis_tlast`.
- `m_axis_tuser`  out  64  FIFO head bits [63:0].
- `m_axis_tready`  in  1  downstream ready.
- `meta_count`  out  $clog2(META_DEPTH)+1  current FIFO occupancy.
- `meta_overflow`  out  1  sticky; a metadata strobe was dropped while the FIFO was full.
- `pkt_count`  out  32  packets emitted; counts `tlast` handshakes and wraps.

## Operation
- Metadata FIFO: a register array with write pointer, read pointer and count. The head is read combinationally (zero read latency).
- Push: occurs when `user_metadata_out_valid` is high and the FIFO is not full. Only bits [63:0] are stored.
- Push while full: the word is dropped, `meta_overflow` is set to 1, and the count is unchanged.
- Pop: occurs on an output handshake with `m_axis_tlast`=1 (`m_axis_tvalid & m_axis_tready & m_axis_tlast`).
- Simultaneous push and pop: both take effect and the count is unchanged. When full, the pop frees a slot, so a push in the same cycle is accepted and `meta_overflow` is not set.
- Gating: `m_axis_tvalid = s_axis_tvalid & ~empty` and `s_axis_tready = m_axis_tready & ~empty`.
  - A packet cannot start until its metadata is queued.
  - The head stays stable for the whole packet because it is popped only on `tlast`.
- `m_axis_tuser` equals the head on every beat, including beats with `tvalid` low. It is don't-care when the FIFO is empty.
- `pkt_count` increments by 1 on each `tlast` handshake and wraps 0xFFFFFFFF→0.
- Packet data, keep and last pass through combinationally; there is no data register.

## Timing
- Reset values:
  - `meta_count`=0, `meta_overflow`=0, `pkt_count`=0, pointers=0.
  - `m_axis_tvalid`=0 and `s_axis_tready`=0, because the FIFO is empty.
- Metadata-to-visible latency is 1 cycle. A strobe in cycle N makes the FIFO non-empty in N+1; there is no same-cycle bypass. A first beat presented in cycle N therefore first asserts `m_axis_tvalid` in N+1.
- Data path latency is 0 cycles, combinational from the s_ side to the m_ side once metadata is present.
- Back-to-back packets: after a `tlast` pop in cycle N, the next head drives `tuser` in N+1. The next packet streams with no bubble if its metadata is already queued.
- Reset asserted mid-packet: the FIFO is flushed and counters are cleared. Remaining beats of the in-flight packet are held off (`s_axis_tready`=0) until new metadata arrives; the P4 core is reset by the same signal.
- `meta_overflow` clears only on reset.

## Test plan
- **Basic join:** strobe metadata 0xA5 in cycle 0, then send a 3-beat packet from cycle 0 with `m_axis_tready`=1.
  - Cycle 0: `m_axis_tvalid`=0.
  - Cycles 1–3: the beats appear with `tuser`=0xA5.
  - After the `tlast` handshake, `meta_count` returns to 0 and `pkt_count`=1.
- **Metadata lag:** packet beats wait 5 cycles before metadata 0x11 arrives.
  - `s_axis_tready` stays 0 throughout the wait.
  - The first beat is emitted 1 cycle after the strobe, with `tuser`=0x11.
- **Queueing and backpressure:** push 0x1, 0x2, 0x3, then send three 2-beat packets while toggling `m_axis_tready` randomly.
  - `tuser` sequence per packet is 0x1, 0x2, 0x3.
  - No beat is lost or duplicated, and `s_axis_tready` mirrors `m_axis_tready`.
- **Overflow:** issue 9 strobes with no packets (`META_DEPTH`=8).
  - `meta_count`=8 and `meta_overflow`=1.
  - The ninth word is absent when the 8 queued packets drain.
- **Full with push and pop together:** with the FIFO full, issue a strobe in the same cycle as a `tlast` handshake.
  - `meta_count` stays 8, `meta_overflow` stays 0, and the new word is emitted last.
- **Reset mid-packet and wrap:**
  - Assert `aresetn`=0 during beat 2 of a packet: all status outputs read 0 and `m_axis_tvalid`=0 the cycle after.
  - Preload `pkt_count` via a forced value 0xFFFFFFFF, then send one packet: `pkt_count`=0.
